sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 119 +++++++++++
 tb/tb_sw_debounce.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Debounces the ten board slide switches. Each switch bit goes through a
// two-flop synchronizer. A change is accepted only after the synchronized
// level has differed from the accepted value for DB_LIMIT consecutive cycles.
// Every accepted change:
//   - produces a one-cycle event pulse, and
//   - sets a sticky "changed" flag that the CPU clears bit by bit.
//
// Parameters
//   DB_LIMIT : consecutive cycles a new level must hold (1..65535)
//   CNT_W    : per-bit counter width, must be able to hold DB_LIMIT-1
//
// Ports
//   clock     : system clock, all state changes on its rising edge
//   resetn    : synchronous active-low reset
//   sw_raw    : asynchronous switch inputs SW[9:0]
//   clr_chg   : per-bit level-sampled clear for sw_chg
//   sw_stable : debounced switch value
//   sw_evt    : one-cycle pulse on each bit whose sw_stable toggles
//   sw_chg    : sticky "changed since last clear" flags
//   chg_any   : OR of all sw_chg bits
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int DB_LIMIT = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] sw_raw,
    input  logic [9:0] clr_chg,
    output logic [9:0] sw_stable,
    output logic [9:0] sw_evt,
    output logic [9:0] sw_chg,
    output logic       chg_any
);

    localparam int N = 10;

    // Terminal count. The toggle happens on the edge where the counter
    // already sits at this value, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_LIMIT - 1);

    typedef enum logic {
        IDLE,
        COUNTING
    } bit_state_t;

    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [CNT_W-1:0] cnt        [N];
    logic [CNT_W-1:0] cnt_next   [N];
    bit_state_t       state      [N];
    logic [N-1:0]     stable_next;
    logic [N-1:0]     evt_next;
    logic [N-1:0]     chg_next;

    // State register for the synchronizer, the per-bit counters and the
    // three registered outputs. sync1 is the only flop that sees sw_raw.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1     <= '0;
            sync2     <= '0;
            sw_stable <= '0;
            sw_evt    <= '0;
            sw_chg    <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= sw_raw;
            sync2     <= sync1;
            sw_stable <= stable_next;
            sw_evt    <= evt_next;
            sw_chg    <= chg_next;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Per-bit next-state logic. A bit is COUNTING whenever its synchronized
    // level disagrees with the accepted value. Any cycle of agreement drops
    // the bit back to IDLE with a zero count, so short glitches are
    // forgotten. In sw_chg, a toggle on the same edge as a clear wins,
    // because the set is applied after the clear.
    always_comb begin
        stable_next = sw_stable;
        evt_next    = '0;
        chg_next    = sw_chg & ~clr_chg;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = '0;
            state[i]    = (sync2[i] != sw_stable[i]) ? COUNTING : IDLE;
            case (state[i])
                IDLE: begin
                    cnt_next[i] = '0;
                end
                COUNTING: begin
                    if (cnt[i] == CNT_MAX) begin
                        stable_next[i] = ~sw_stable[i];
                        evt_next[i]    = 1'b1;
                        chg_next[i]    = 1'b1;
                        cnt_next[i]    = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_next[i] = '0;
                end
            endcase
        end
    end

    // chg_any is combinational so the CPU sees it together with sw_chg.
    assign chg_any = |sw_chg;

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
//
// Self-checking bench for sw_debounce with DB_LIMIT=4. A second instance with
// DB_LIMIT=1 shares the same inputs and is spot-checked for the minimum
// synchronizer-only latency.
//
// The reference model works on edge timestamps. For each bit it keeps the
// edge at which the synchronized input last agreed with the accepted value,
// or was last reset or toggled. A toggle is due once the input has
// disagreed for DB_LIMIT edges since that timestamp.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int DB_LIMIT = 4;

    logic       clock;
    logic       resetn;
    logic [9:0] sw_raw;
    logic [9:0] clr_chg;
    logic [9:0] sw_stable,  sw_evt,  sw_chg;
    logic       chg_any;
    logic [9:0] sw_stable1, sw_evt1, sw_chg1;
    logic       chg_any1;

    int assertCount = 0;
    int failCount   = 0;

    sw_debounce #(.DB_LIMIT(DB_LIMIT), .CNT_W(16)) u_dut (
        .clock     (clock),
        .resetn    (resetn),
        .sw_raw    (sw_raw),
        .clr_chg   (clr_chg),
        .sw_stable (sw_stable),
        .sw_evt    (sw_evt),
        .sw_chg    (sw_chg),
        .chg_any   (chg_any)
    );

    sw_debounce #(.DB_LIMIT(1), .CNT_W(16)) u_dut1 (
        .clock     (clock),
        .resetn    (resetn),
        .sw_raw    (sw_raw),
        .clr_chg   (clr_chg),
        .sw_stable (sw_stable1),
        .sw_evt    (sw_evt1),
        .sw_chg    (sw_chg1),
        .chg_any   (chg_any1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared comparison helper; every check in the bench goes through here.
    task automatic checkVal(input string name, input logic [9:0] act, input logic [9:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on every rising edge from the same inputs
    // the DUT sees.
    int         edgeN = 0;
    int         lastAgree [10];
    logic [9:0] ms1, ms2, mStable, mEvt, mChg;
    bit         modelValid = 0;

    always @(posedge clock) begin
        edgeN++;
        if (!resetn) begin
            ms1 = '0; ms2 = '0; mStable = '0; mEvt = '0; mChg = '0;
            for (int b = 0; b < 10; b++) lastAgree[b] = edgeN;
            modelValid = 1;
        end else if (modelValid) begin
            for (int b = 0; b < 10; b++) begin
                mEvt[b] = 1'b0;
                if (ms2[b] == mStable[b]) begin
                    lastAgree[b] = edgeN;
                end else if (edgeN - lastAgree[b] >= DB_LIMIT) begin
                    mStable[b]   = ~mStable[b];
                    mEvt[b]      = 1'b1;
                    lastAgree[b] = edgeN;
                end
            end
            mChg = (mChg & ~clr_chg) | mEvt;
            ms2  = ms1;
            ms1  = sw_raw;
        end
    end

    // Compare process: outputs are checked against the model on every
    // falling edge once the first reset has defined the state.
    always @(negedge clock) begin
        if (modelValid) begin
            checkVal("model_stable", sw_stable, mStable);
            checkVal("model_evt",    sw_evt,    mEvt);
            checkVal("model_chg",    sw_chg,    mChg);
            checkVal("model_any",    {9'd0, chg_any}, {9'd0, |mChg});
        end
    end

    // Drive inputs on a falling edge so they are settled at the next rise.
    task automatic applyStimulus(input logic [9:0] raw, input logic [9:0] clr, input logic rstn);
        sw_raw  = raw;
        clr_chg = clr;
        resetn  = rstn;
    endtask

    // Advance n rising edges; returns just after the following falling edge.
    task automatic stepCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Hand-computed literal expectations for the main instance.
    task automatic checkOutput(input string name, input logic [9:0] eStable,
                               input logic [9:0] eEvt, input logic [9:0] eChg,
                               input logic eAny);
        checkVal({name, "_stable"}, sw_stable, eStable);
        checkVal({name, "_evt"},    sw_evt,    eEvt);
        checkVal({name, "_chg"},    sw_chg,    eChg);
        checkVal({name, "_any"},    {9'd0, chg_any}, {9'd0, eAny});
    endtask

    initial begin
        applyStimulus(10'h000, 10'h000, 1'b0);
        stepCycles(3);
        checkOutput("reset", 10'h000, 10'h000, 10'h000, 1'b0);
        checkVal("reset1_stable", sw_stable1, 10'h000);

        // Single bit held high: accepted on edge 6 (edge 3 for DB_LIMIT=1).
        applyStimulus(10'h001, 10'h000, 1'b1);
        stepCycles(2);
        checkVal("lim1_edge2_stable", sw_stable1, 10'h000);
        stepCycles(1);
        checkVal("lim1_edge3_stable", sw_stable1, 10'h001);
        checkVal("lim1_edge3_evt",    sw_evt1,    10'h001);
        stepCycles(2);
        checkOutput("edge5", 10'h000, 10'h000, 10'h000, 1'b0);
        stepCycles(1);
        checkOutput("edge6", 10'h001, 10'h001, 10'h001, 1'b1);
        stepCycles(1);
        checkOutput("edge7", 10'h001, 10'h000, 10'h001, 1'b1);

        // Short glitch on bit 3 after a fresh reset.
        applyStimulus(10'h000, 10'h000, 1'b0);
        stepCycles(2);
        checkOutput("reset2", 10'h000, 10'h000, 10'h000, 1'b0);
        applyStimulus(10'h008, 10'h000, 1'b1);
        stepCycles(3);
        applyStimulus(10'h000, 10'h000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            stepCycles(1);
            checkVal("glitch_stable", sw_stable, 10'h000);
            checkVal("glitch_evt",    sw_evt,    10'h000);
        end
        checkOutput("glitch_end", 10'h000, 10'h000, 10'h000, 1'b0);

        // All high, clear the flags, then all low with clear on toggle edge.
        applyStimulus(10'h3FF, 10'h000, 1'b1);
        stepCycles(6);
        checkOutput("all_high", 10'h3FF, 10'h3FF, 10'h3FF, 1'b1);
        applyStimulus(10'h3FF, 10'h3FF, 1'b1);
        stepCycles(1);
        checkOutput("all_cleared", 10'h3FF, 10'h000, 10'h000, 1'b0);
        applyStimulus(10'h000, 10'h000, 1'b1);
        stepCycles(5);
        applyStimulus(10'h000, 10'h3FF, 1'b1);
        stepCycles(1);
        checkOutput("set_wins", 10'h000, 10'h3FF, 10'h3FF, 1'b1);

        // Partial clears of the sticky flags.
        applyStimulus(10'h000, 10'h3FF, 1'b1);
        stepCycles(1);
        applyStimulus(10'h0A0, 10'h000, 1'b1);
        stepCycles(6);
        checkOutput("chg_0a0", 10'h0A0, 10'h0A0, 10'h0A0, 1'b1);
        applyStimulus(10'h0A0, 10'h020, 1'b1);
        stepCycles(1);
        applyStimulus(10'h0A0, 10'h000, 1'b1);
        checkOutput("clr_020", 10'h0A0, 10'h000, 10'h080, 1'b1);
        applyStimulus(10'h0A0, 10'h080, 1'b1);
        stepCycles(1);
        applyStimulus(10'h0A0, 10'h000, 1'b1);
        checkOutput("clr_080", 10'h0A0, 10'h000, 10'h000, 1'b0);

        // Bit 9 changes; reset at count 2 abandons it, then it is re-accepted.
        applyStimulus(10'h2A0, 10'h000, 1'b1);
        stepCycles(4);
        applyStimulus(10'h2A0, 10'h000, 1'b0);
        stepCycles(1);
        checkOutput("mid_reset", 10'h000, 10'h000, 10'h000, 1'b0);
        applyStimulus(10'h2A0, 10'h000, 1'b1);
        stepCycles(5);
        checkOutput("post_reset_e5", 10'h000, 10'h000, 10'h000, 1'b0);
        stepCycles(1);
        checkOutput("post_reset_e6", 10'h2A0, 10'h2A0, 10'h2A0, 1'b1);

        // Bits 0 and 9 change two cycles apart.
        applyStimulus(10'h2A0, 10'h3FF, 1'b1);
        stepCycles(1);
        applyStimulus(10'h2A1, 10'h000, 1'b1);
        stepCycles(2);
        applyStimulus(10'h0A1, 10'h000, 1'b1);
        stepCycles(4);
        checkOutput("stagger_b0", 10'h2A1, 10'h001, 10'h001, 1'b1);
        stepCycles(1);
        checkOutput("stagger_gap", 10'h2A1, 10'h000, 10'h001, 1'b1);
        stepCycles(1);
        checkOutput("stagger_b9", 10'h0A1, 10'h200, 10'h201, 1'b1);
        stepCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
